// File: rtl/alu_result_serializer_pkg.sv
// Shared definitions for the ALU result serializer: FSM state encoding,
// flag bit positions and small width/frame-length helpers.
package alu_result_serializer_pkg;

    // Serializer FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_FLAGS  = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } ser_state_t;

    // Positions of the individual ALU status flags inside the flags bus
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // Total bits on the line for one frame: start + data + flags + parity + stop
    function automatic int frame_bits(input int data_w, input int flag_w);
        return data_w + flag_w + 3;
    endfunction

    // Width of the bit-period down counter, never narrower than one bit
    function automatic int timer_width(input int bit_cycles);
        return (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
    endfunction

    // Width of the bit counter that has to cover both the data and flag fields
    function automatic int count_width(input int data_w, input int flag_w);
        int widest;
        widest = (data_w > flag_w) ? data_w : flag_w;
        return (widest > 1) ? $clog2(widest) : 1;
    endfunction

endpackage

// File: rtl/alu_result_serializer_bit_timer.sv
// Bit-period timer: counts BIT_CYCLES-1 down to 0 and flags the last clock
// of every bit period. A restart realigns the period to the current edge.
module bit_timer
    import alu_result_serializer_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int EFF_CYCLES = (BIT_CYCLES < 1) ? 1 : BIT_CYCLES;
    localparam int TW = timer_width(EFF_CYCLES);
    localparam logic [TW-1:0] RELOAD = TW'(EFF_CYCLES - 1);

    logic [TW-1:0] count;

    // Down counter that reloads on restart or when a period runs out
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (restart || (count == '0)) begin
            count <= RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/alu_result_serializer.sv
// Serializes one ALU result plus its status flags into a framed stream on a
// single line: start(0), result LSB first, flags LSB first, even parity, stop(1).
// The line idles high and every bit is held for BIT_CYCLES clocks.
module alu_result_serializer
    import alu_result_serializer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FLAG_W     = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] result,
    input  logic [FLAG_W-1:0] flags,
    output logic              ser_out,
    output logic              ser_active,
    output logic              done
);

    localparam int SHIFT_W = DATA_W + FLAG_W + 1;
    localparam int CW      = count_width(DATA_W, FLAG_W);
    localparam logic [CW-1:0] DATA_RELOAD = CW'(DATA_W - 1);
    localparam logic [CW-1:0] FLAG_RELOAD = CW'(FLAG_W - 1);

    ser_state_t         state;
    logic [SHIFT_W-1:0] shreg;
    logic [CW-1:0]      bitcnt;
    logic               accept;
    logic               tick;

    // Ready comes straight from the state register, so there is no input-to-output path
    assign load_ready = (state == ST_IDLE);
    assign accept     = load_valid && (state == ST_IDLE);

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    // Frame sequencer: captures the payload on accept and walks it out one bit per period
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ser_out    <= 1'b1;
            ser_active <= 1'b0;
            done       <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        state      <= ST_START;
                        ser_out    <= 1'b0;
                        ser_active <= 1'b1;
                        shreg      <= {^{flags, result}, flags, result};
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        ser_out <= shreg[0];
                        shreg   <= {1'b0, shreg[SHIFT_W-1:1]};
                        bitcnt  <= DATA_RELOAD;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        ser_out <= shreg[0];
                        shreg   <= {1'b0, shreg[SHIFT_W-1:1]};
                        if (bitcnt == '0) begin
                            state  <= ST_FLAGS;
                            bitcnt <= FLAG_RELOAD;
                        end else begin
                            bitcnt <= bitcnt - 1'b1;
                        end
                    end
                end
                ST_FLAGS: begin
                    if (tick) begin
                        ser_out <= shreg[0];
                        shreg   <= {1'b0, shreg[SHIFT_W-1:1]};
                        if (bitcnt == '0) begin
                            state <= ST_PARITY;
                        end else begin
                            bitcnt <= bitcnt - 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state   <= ST_STOP;
                        ser_out <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state      <= ST_IDLE;
                        ser_active <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ser_out    <= 1'b1;
                    ser_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
